// File: rtl/fma16_vec_checker_if.sv
// Pin bundle between the vector checker and the half-precision FMA under test.
// The checker drives operands and controls and observes result and flags.
interface fma16_vec_checker_if;
  logic [15:0] x;
  logic [15:0] y;
  logic [15:0] z;
  logic        mul;
  logic        add;
  logic        negp;
  logic        negz;
  logic [1:0]  roundmode;
  logic [15:0] result;
  logic [3:0]  flags;

  modport master (
    output x, y, z, mul, add, negp, negz, roundmode,
    input  result, flags
  );

  modport slave (
    input  x, y, z, mul, add, negp, negz, roundmode,
    output result, flags
  );
endinterface

// File: rtl/fma16_vec_checker.sv
// Self-checking vector sequencer for the fma16 unit: fetches packed vectors from a
// synchronous-read memory, drives them onto the FMA pins, waits LAT cycles, then
// compares result/flags against the expected values and accumulates status.
module fma16_vec_checker #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LAT       = 0,
  parameter bit          CHK_FLAGS = 1'b1,
  localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [AW:0]          num_vec,
  output logic                 vec_rd,
  output logic [AW-1:0]        vec_addr,
  input  logic [75:0]          vec_data,
  fma16_vec_checker_if.master  fma,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          err_count,
  output logic [AW-1:0]        first_err_idx,
  output logic [15:0]          first_err_result,
  output logic [3:0]           first_err_flags
);

  localparam int unsigned CW      = (LAT > 1) ? $clog2(LAT) : 1;
  localparam bit          HasWait = (LAT > 0);
  localparam logic [CW-1:0] CntInit = HasWait ? CW'(LAT - 1) : '0;
  localparam logic [AW:0]   DepthW  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StLoad,
    StWait,
    StCheck,
    StDone
  } state_e;

  state_e        state_q;
  logic [AW-1:0] idx_q;
  logic [AW:0]   n_q;
  logic [CW-1:0] cnt_q;
  logic          vec_rd_q;
  logic [AW-1:0] vec_addr_q;
  logic          busy_q;
  logic          done_q;
  logic          pass_q;
  logic [15:0]   err_q;
  logic [AW-1:0] ferr_idx_q;
  logic [15:0]   ferr_res_q;
  logic [3:0]    ferr_flg_q;

  // Operand/control registers and the expected values of the loaded vector
  logic [15:0]   x_q;
  logic [15:0]   y_q;
  logic [15:0]   z_q;
  logic          mul_q;
  logic          add_q;
  logic          negp_q;
  logic          negz_q;
  logic [1:0]    rm_q;
  logic [15:0]   rexp_q;
  logic [3:0]    fexp_q;

  logic [AW:0]   num_clamped;
  logic          last_vec;
  logic          res_ok;
  logic          flg_ok;
  logic          mismatch;
  logic [15:0]   err_next;
  logic          unused_ctrl;

  // Exponent all-ones with non-zero mantissa; sign and payload do not matter.
  function automatic logic is_nan(input logic [15:0] v);
    return (v[14:10] == 5'h1F) && (v[9:0] != 10'h000);
  endfunction

  // Clamp the requested vector count, decode the last index and evaluate the match
  always_comb begin
    num_clamped = (num_vec > DepthW) ? DepthW : num_vec;
    last_vec    = ({1'b0, idx_q} == (n_q - (AW + 1)'(1)));
    res_ok      = (fma.result == rexp_q) || (is_nan(fma.result) && is_nan(rexp_q));
    flg_ok      = !CHK_FLAGS || (fma.flags == fexp_q);
    mismatch    = !(res_ok && flg_ok);
    err_next    = err_q;
    if (mismatch && (err_q != 16'hFFFF)) begin
      err_next = err_q + 16'd1;
    end
  end

  // The two pad bits of the control byte carry no meaning
  assign unused_ctrl = ^vec_data[27:26];

  // Sequencer FSM; every output is a register updated here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      vec_rd_q   <= 1'b0;
      vec_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      ferr_idx_q <= '0;
      ferr_res_q <= '0;
      ferr_flg_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      mul_q      <= 1'b0;
      add_q      <= 1'b0;
      negp_q     <= 1'b0;
      negz_q     <= 1'b0;
      rm_q       <= '0;
      rexp_q     <= '0;
      fexp_q     <= '0;
    end else begin
      vec_rd_q <= 1'b0;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            idx_q      <= '0;
            n_q        <= num_clamped;
            err_q      <= '0;
            ferr_idx_q <= '0;
            ferr_res_q <= '0;
            ferr_flg_q <= '0;
            if (num_clamped == '0) begin
              // Empty run completes immediately and trivially passes
              state_q <= StDone;
              done_q  <= 1'b1;
              pass_q  <= 1'b1;
            end else begin
              state_q    <= StFetch;
              done_q     <= 1'b0;
              pass_q     <= 1'b0;
              busy_q     <= 1'b1;
              vec_rd_q   <= 1'b1;
              vec_addr_q <= '0;
            end
          end
        end
        StFetch: begin
          state_q <= StLoad;
        end
        StLoad: begin
          x_q    <= vec_data[75:60];
          y_q    <= vec_data[59:44];
          z_q    <= vec_data[43:28];
          rm_q   <= vec_data[25:24];
          mul_q  <= vec_data[23];
          add_q  <= vec_data[22];
          negp_q <= vec_data[21];
          negz_q <= vec_data[20];
          rexp_q <= vec_data[19:4];
          fexp_q <= vec_data[3:0];
          if (HasWait) begin
            cnt_q   <= CntInit;
            state_q <= StWait;
          end else begin
            state_q <= StCheck;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StCheck;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StCheck: begin
          err_q <= err_next;
          // err_count saturates, so zero reliably means no earlier mismatch
          if (mismatch && (err_q == '0)) begin
            ferr_idx_q <= idx_q;
            ferr_res_q <= fma.result;
            ferr_flg_q <= fma.flags;
          end
          if (last_vec) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_next == '0);
          end else begin
            idx_q      <= idx_q + 1'b1;
            state_q    <= StFetch;
            vec_rd_q   <= 1'b1;
            vec_addr_q <= idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign vec_rd           = vec_rd_q;
  assign vec_addr         = vec_addr_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_err_idx    = ferr_idx_q;
  assign first_err_result = ferr_res_q;
  assign first_err_flags  = ferr_flg_q;

  assign fma.x         = x_q;
  assign fma.y         = y_q;
  assign fma.z         = z_q;
  assign fma.mul       = mul_q;
  assign fma.add       = add_q;
  assign fma.negp      = negp_q;
  assign fma.negz      = negz_q;
  assign fma.roundmode = rm_q;

endmodule

// File: tb/tb_fma16_vec_checker.sv
// Directed bench for fma16_vec_checker. Three checkers share one vector memory:
// u_dut0 (LAT 0, flags checked), u_dut1 (LAT 0, flags ignored), u_dut2 (LAT 2).
// The stand-in FMA returns result = x and flags = y[3:0], so each vector's expected
// values decide by construction whether it should match.
module tb_fma16_vec_checker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  start_v;
  logic [4:0]  num_vec;
  logic [2:0]  vec_rd_v;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  pass_v;
  logic [3:0]  addr_v [3];
  logic [75:0] rdata  [3];
  logic [15:0] err_v  [3];
  logic [3:0]  fidx_v [3];
  logic [15:0] fres_v [3];
  logic [3:0]  fflg_v [3];
  logic [75:0] mem    [16];

  logic [15:0] p1_res, p2_res;
  logic [3:0]  p1_flg, p2_flg;

  int checks = 0;
  int errors = 0;
  int cyc, rds;
  logic [3:0] first_a, last_a;
  logic       busy_ok;

  always #5 clk = ~clk;

  fma16_vec_checker_if u_if0 ();
  fma16_vec_checker_if u_if1 ();
  fma16_vec_checker_if u_if2 ();

  // Stand-in FMA: combinational for LAT 0, two-stage pipeline for LAT 2
  assign u_if0.result = u_if0.x;
  assign u_if0.flags  = u_if0.y[3:0];
  assign u_if1.result = u_if1.x;
  assign u_if1.flags  = u_if1.y[3:0];
  always @(posedge clk) begin
    p1_res <= u_if2.x;
    p1_flg <= u_if2.y[3:0];
    p2_res <= p1_res;
    p2_flg <= p1_flg;
  end
  assign u_if2.result = p2_res;
  assign u_if2.flags  = p2_flg;

  // Synchronous-read vector memory, one read port per checker
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vec_rd_v[i]) rdata[i] <= mem[addr_v[i]];
    end
  end

  fma16_vec_checker #(.DEPTH(16), .LAT(0), .CHK_FLAGS(1'b1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start_v[0]), .num_vec(num_vec),
    .vec_rd(vec_rd_v[0]), .vec_addr(addr_v[0]), .vec_data(rdata[0]), .fma(u_if0),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .err_count(err_v[0]),
    .first_err_idx(fidx_v[0]), .first_err_result(fres_v[0]), .first_err_flags(fflg_v[0])
  );

  fma16_vec_checker #(.DEPTH(16), .LAT(0), .CHK_FLAGS(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start_v[1]), .num_vec(num_vec),
    .vec_rd(vec_rd_v[1]), .vec_addr(addr_v[1]), .vec_data(rdata[1]), .fma(u_if1),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .err_count(err_v[1]),
    .first_err_idx(fidx_v[1]), .first_err_result(fres_v[1]), .first_err_flags(fflg_v[1])
  );

  fma16_vec_checker #(.DEPTH(16), .LAT(2), .CHK_FLAGS(1'b1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start(start_v[2]), .num_vec(num_vec),
    .vec_rd(vec_rd_v[2]), .vec_addr(addr_v[2]), .vec_data(rdata[2]), .fma(u_if2),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .err_count(err_v[2]),
    .first_err_idx(fidx_v[2]), .first_err_result(fres_v[2]), .first_err_flags(fflg_v[2])
  );

  function automatic logic [75:0] mk(input logic [15:0] x, input logic [15:0] y,
                                     input logic [15:0] z, input logic [7:0] ctrl,
                                     input logic [15:0] rexp, input logic [3:0] fexp);
    return {x, y, z, ctrl, rexp, fexp};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on checker sel, then count cycles from busy rising until done.
  // A non-zero mid re-pulses start that many cycles into the run.
  task automatic run(input int sel, input logic [4:0] n, input int mid);
    num_vec      = n;
    start_v[sel] = 1'b1;
    step();
    start_v[sel] = 1'b0;
    busy_ok = busy_v[sel];
    cyc = 0;
    rds = 0;
    first_a = 4'hF;
    last_a  = 4'hF;
    if (vec_rd_v[sel]) begin
      rds++;
      first_a = addr_v[sel];
      last_a  = addr_v[sel];
    end
    while (!done_v[sel] && cyc < 200) begin
      step();
      cyc++;
      start_v[sel] = (mid > 0) && (cyc == mid);
      if (vec_rd_v[sel]) begin
        if (rds == 0) first_a = addr_v[sel];
        rds++;
        last_a = addr_v[sel];
      end
    end
    start_v[sel] = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    start_v = '0;
    num_vec = '0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    step();
    step();
    chk("rst_busy", 32'(busy_v), 32'h0);
    chk("rst_done", 32'(done_v), 32'h0);
    chk("rst_pass", 32'(pass_v), 32'h0);
    chk("rst_vec_rd", 32'(vec_rd_v), 32'h0);
    chk("rst_err", 32'(err_v[0]), 32'h0);
    chk("rst_x", 32'(u_if0.x), 32'h0);
    reset_n = 1'b1;
    step();

    // Single vector 1.0 * 1.0 with mul set
    mem[0] = mk(16'h3c00, 16'h3c00, 16'h0000, 8'h08, 16'h3c00, 4'h0);
    run(0, 5'd1, 0);
    chk("a_busy_rise", 32'(busy_ok), 32'h1);
    chk("a_cycles", 32'(cyc), 32'd3);
    chk("a_rd_pulses", 32'(rds), 32'd1);
    chk("a_rd_addr", 32'(first_a), 32'h0);
    chk("a_mul", 32'(u_if0.mul), 32'h1);
    chk("a_x", 32'(u_if0.x), 32'h3c00);
    chk("a_pass", 32'(pass_v[0]), 32'h1);
    chk("a_err", 32'(err_v[0]), 32'h0);
    chk("a_busy_fall", 32'(busy_v[0]), 32'h0);

    // Four vectors, wrong result on index 2; last vector exercises other controls
    mem[0] = mk(16'h4000, 16'h0000, 16'h0000, 8'h08, 16'h4000, 4'h0);
    mem[1] = mk(16'h4001, 16'h0000, 16'h0000, 8'h08, 16'h4001, 4'h0);
    mem[2] = mk(16'h3c01, 16'h0000, 16'h0000, 8'h08, 16'h3c00, 4'h0);
    mem[3] = mk(16'h4003, 16'h0000, 16'h1234, 8'h35, 16'h4003, 4'h0);
    run(0, 5'd4, 0);
    chk("b_cycles", 32'(cyc), 32'd12);
    chk("b_rd_pulses", 32'(rds), 32'd4);
    chk("b_last_addr", 32'(last_a), 32'h3);
    chk("b_err", 32'(err_v[0]), 32'h1);
    chk("b_first_idx", 32'(fidx_v[0]), 32'h2);
    chk("b_first_res", 32'(fres_v[0]), 32'h3c01);
    chk("b_first_flg", 32'(fflg_v[0]), 32'h0);
    chk("b_pass", 32'(pass_v[0]), 32'h0);
    chk("b_ctrl", 32'({u_if0.roundmode, u_if0.mul, u_if0.add, u_if0.negp, u_if0.negz}),
        32'h35);
    chk("b_z", 32'(u_if0.z), 32'h1234);

    // Quiet NaN expected, negative NaN with other payload returned
    mem[0] = mk(16'hfc01, 16'h0000, 16'h0000, 8'h08, 16'h7e00, 4'h0);
    run(0, 5'd1, 0);
    chk("c_nan_pass", 32'(pass_v[0]), 32'h1);
    chk("c_nan_err", 32'(err_v[0]), 32'h0);

    // Infinity expected, NaN returned
    mem[0] = mk(16'h7c01, 16'h0000, 16'h0000, 8'h08, 16'h7c00, 4'h0);
    run(0, 5'd1, 0);
    chk("c_inf_err", 32'(err_v[0]), 32'h1);
    chk("c_inf_pass", 32'(pass_v[0]), 32'h0);
    chk("c_inf_res", 32'(fres_v[0]), 32'h7c01);

    // Flags mismatch: NX returned where none expected
    mem[0] = mk(16'h3c00, 16'h0001, 16'h0000, 8'h08, 16'h3c00, 4'h0);
    run(0, 5'd1, 0);
    chk("d_flg_err", 32'(err_v[0]), 32'h1);
    chk("d_flg_first", 32'(fflg_v[0]), 32'h1);
    run(1, 5'd1, 0);
    chk("d_noflg_pass", 32'(pass_v[1]), 32'h1);
    chk("d_noflg_err", 32'(err_v[1]), 32'h0);

    // Two-cycle pipelined FMA, stray start partway through
    mem[0] = mk(16'h4100, 16'h0000, 16'h0000, 8'h08, 16'h4100, 4'h0);
    mem[1] = mk(16'h4200, 16'h0000, 16'h0000, 8'h08, 16'h4200, 4'h0);
    mem[2] = mk(16'h4300, 16'h0000, 16'h0000, 8'h08, 16'h4300, 4'h0);
    run(2, 5'd3, 6);
    chk("e_cycles", 32'(cyc), 32'd15);
    chk("e_rd_pulses", 32'(rds), 32'd3);
    chk("e_err", 32'(err_v[2]), 32'h0);
    chk("e_pass", 32'(pass_v[2]), 32'h1);

    // Empty run on a checker holding an error from before
    num_vec    = 5'd0;
    start_v[0] = 1'b1;
    step();
    start_v[0] = 1'b0;
    chk("f_zero_done", 32'(done_v[0]), 32'h1);
    chk("f_zero_busy", 32'(busy_v[0]), 32'h0);
    chk("f_zero_pass", 32'(pass_v[0]), 32'h1);
    chk("f_zero_err", 32'(err_v[0]), 32'h0);

    // Oversized count clamps to the 16-entry depth
    for (int k = 0; k < 16; k++) begin
      mem[k] = mk(16'(16'h4400 + k), 16'h0000, 16'h0000, 8'h08, 16'(16'h4400 + k), 4'h0);
    end
    run(0, 5'd31, 0);
    chk("g_clamp_cycles", 32'(cyc), 32'd48);
    chk("g_clamp_rds", 32'(rds), 32'd16);
    chk("g_clamp_last", 32'(last_a), 32'hF);
    chk("g_clamp_pass", 32'(pass_v[0]), 32'h1);

    // Reset asserted while vector 1 waits in the pipeline
    mem[0] = mk(16'h4100, 16'h0000, 16'h0000, 8'h08, 16'h4100, 4'h0);
    mem[1] = mk(16'h4200, 16'h0000, 16'h0000, 8'h08, 16'h4200, 4'h0);
    mem[2] = mk(16'h4300, 16'h0000, 16'h0000, 8'h08, 16'h4300, 4'h0);
    num_vec    = 5'd3;
    start_v[2] = 1'b1;
    step();
    start_v[2] = 1'b0;
    repeat (7) step();
    chk("h_pre_busy", 32'(busy_v[2]), 32'h1);
    chk("h_pre_x", 32'(u_if2.x), 32'h4200);
    reset_n = 1'b0;
    #1;
    chk("h_rst_busy", 32'(busy_v[2]), 32'h0);
    chk("h_rst_x", 32'(u_if2.x), 32'h0);
    step();
    chk("h_rst_done", 32'(done_v[2]), 32'h0);
    chk("h_rst_rd", 32'(vec_rd_v[2]), 32'h0);
    chk("h_rst_pass", 32'(pass_v[2]), 32'h0);
    reset_n = 1'b1;
    step();
    run(2, 5'd3, 0);
    chk("h_rerun_first", 32'(first_a), 32'h0);
    chk("h_rerun_cycles", 32'(cyc), 32'd15);
    chk("h_rerun_pass", 32'(pass_v[2]), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
